vote_input_conditioner: RTL



---
 rtl/vote_input_conditioner.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vote_input_conditioner.sv
// Front-end conditioner for three raw vote buttons. Each button goes through a
// two-flop synchroniser and a counter-based debouncer, then a small arbiter FSM
// turns clean press events into at most one single-cycle vote (or conflict)
// pulse per physical press, followed by a hold-off window and a wait for all
// buttons to be released.
module vote_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLDOFF_CYCLES  = 32,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       btn_A,
    input  logic       btn_B,
    input  logic       btn_C,
    output logic       vote_A,
    output logic       vote_B,
    output logic       vote_C,
    output logic       conflict,
    output logic       busy,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_HOLDOFF      = 2'b01,
        ST_WAIT_RELEASE = 2'b10
    } state_t;

    // Terminal counts: the debounce counter toggles the stable level on the
    // cycle it would reach DEBOUNCE_CYCLES; hold-off lasts HOLDOFF_CYCLES cycles.
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HO_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

    logic [2:0]       raw_btn;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       stable;
    logic [2:0]       stable_d;
    logic [CNT_W-1:0] db_cnt [3];
    logic [2:0]       rise;
    logic [1:0]       rise_cnt;

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       vote_q;
    logic             conflict_q;

    // Bit 0 = A, bit 1 = B, bit 2 = C throughout.
    assign raw_btn = {btn_C, btn_B, btn_A};

    // Two-flop synchroniser for the asynchronous button inputs.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its source; blocking here would collapse the two
    // synchroniser stages into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_btn;
            sync2 <= sync1;
        end
    end

    // Per-button debounce: the stable level only follows the synchronised input
    // after DEBOUNCE_CYCLES consecutive differing samples; presses and releases
    // are treated identically.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            stable_d <= stable;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == stable[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    stable[i] <= ~stable[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // One-cycle press events and how many of them coincide.
    assign rise     = stable & ~stable_d;
    assign rise_cnt = 2'(rise[0]) + 2'(rise[1]) + 2'(rise[2]);

    // Arbiter FSM with registered vote/conflict pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            vote_q     <= '0;
            conflict_q <= 1'b0;
        end else begin
            // Pulses are single-cycle unless re-asserted below.
            vote_q     <= '0;
            conflict_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise_cnt == 2'd1) begin
                        if (enable) begin
                            vote_q   <= rise;
                            hold_cnt <= '0;
                            state    <= ST_HOLDOFF;
                        end else begin
                            // Disabled: consume the press silently.
                            state <= ST_WAIT_RELEASE;
                        end
                    end else if (rise_cnt > 2'd1) begin
                        conflict_q <= 1'b1;
                        state      <= ST_WAIT_RELEASE;
                    end
                end
                ST_HOLDOFF: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    if (hold_cnt == HO_LAST) begin
                        state <= ST_WAIT_RELEASE;
                    end
                end
                ST_WAIT_RELEASE: begin
                    // Leaving only with all levels low keeps IDLE's entry
                    // invariant, so a held button can never vote twice.
                    if (stable == 3'b000) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign vote_A    = vote_q[0];
    assign vote_B    = vote_q[1];
    assign vote_C    = vote_q[2];
    assign conflict  = conflict_q;
    assign busy      = (state != ST_IDLE);
    assign state_out = state;

endmodule
